// File: rtl/median_window_6.sv
// rtl/median_window_6.sv - 6-deep sliding window feeder for the median sort network
module median_window_6 #(
    parameter int STRIDE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [31:0]      win_0,
    output logic [31:0]      win_1,
    output logic [31:0]      win_2,
    output logic [31:0]      win_3,
    output logic [31:0]      win_4,
    output logic [31:0]      win_5,
    output logic [CNT_W-1:0] win_count
);

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

    localparam logic [2:0] FILL_FULL   = 3'd6;
    localparam logic [2:0] FILL_LAST   = 3'd5;
    localparam logic [2:0] STRIDE_LAST = 3'(STRIDE - 1);

    logic [31:0] sr      [6];
    logic [31:0] sr_next [6];
    logic [31:0] win_r   [6];

    logic [2:0]  fill_cnt;
    logic [2:0]  fill_next;
    logic [2:0]  stride_cnt;
    logic [2:0]  stride_next;
    state_t      state;
    logic        accept;
    logic        emit;
    logic        handoff;

    // A pending window blocks new samples so nothing is overwritten before it is consumed
    assign in_ready = !rst && !clear && (!win_valid || win_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = win_valid && win_ready;

    assign win_0 = win_r[0];
    assign win_1 = win_r[1];
    assign win_2 = win_r[2];
    assign win_3 = win_r[3];
    assign win_4 = win_r[4];
    assign win_5 = win_r[5];

    // Shift register contents as they will be after accepting in_data
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            sr_next[i] = sr[i + 1];
        end
        sr_next[5] = in_data;
    end

    // Fill/run mode decode plus counter updates and the emit decision
    always_comb begin
        state       = (fill_cnt == FILL_FULL) ? ST_RUN : ST_FILL;
        fill_next   = fill_cnt;
        stride_next = stride_cnt;
        emit        = 1'b0;
        if (accept) begin
            case (state)
                ST_FILL: begin
                    fill_next = fill_cnt + 3'd1;
                    if (fill_cnt == FILL_LAST) begin
                        emit        = 1'b1;
                        stride_next = 3'd0;
                    end
                end
                ST_RUN: begin
                    if (stride_cnt == STRIDE_LAST) begin
                        emit        = 1'b1;
                        stride_next = 3'd0;
                    end else begin
                        stride_next = stride_cnt + 3'd1;
                    end
                end
                default: begin
                    emit = 1'b0;
                end
            endcase
        end
    end

    // Sample history, window register and hand-off bookkeeping; rst beats clear beats traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                sr[i]    <= '0;
                win_r[i] <= '0;
            end
            fill_cnt   <= '0;
            stride_cnt <= '0;
            win_valid  <= 1'b0;
            win_count  <= '0;
        end else if (clear) begin
            fill_cnt   <= '0;
            stride_cnt <= '0;
            win_valid  <= 1'b0;
        end else begin
            if (accept) begin
                sr         <= sr_next;
                fill_cnt   <= fill_next;
                stride_cnt <= stride_next;
            end
            if (handoff) begin
                win_count <= win_count + CNT_W'(1);
            end
            if (emit) begin
                win_r     <= sr_next;
                win_valid <= 1'b1;
            end else if (handoff) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_median_window_6.sv
// tb/tb_median_window_6.sv - scoreboard bench for median_window_6
module tb_median_window_6;

    logic        clk = 1'b0;
    logic [3:0]  rst = 4'hF;
    logic [3:0]  clear = 4'h0;
    logic [3:0]  in_valid = 4'h0;
    logic [3:0]  win_ready = 4'h0;
    logic [3:0]  in_ready;
    logic [3:0]  win_valid;
    logic [31:0] in_data [4];
    logic [31:0] win [4][6];
    logic [15:0] wc [4];

    logic [191:0] expq [4][$];
    string        p_name [$];
    logic [31:0]  p_act [$];
    logic [31:0]  p_exp [$];

    int n_vec = 0;
    int n_bad = 0;
    bit done = 1'b0;
    bit final_done = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: STRIDE 1, instance 1: STRIDE 3, instances 2/3: STRIDE 2/6 with 3-bit count
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S  = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 6;
        localparam int CW = (g < 2) ? 16 : 3;
        logic [CW-1:0] cnt;
        median_window_6 #(.STRIDE(S), .CNT_W(CW)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .clear     (clear[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .win_valid (win_valid[g]),
            .win_ready (win_ready[g]),
            .win_0     (win[g][0]),
            .win_1     (win[g][1]),
            .win_2     (win[g][2]),
            .win_3     (win[g][3]),
            .win_4     (win[g][4]),
            .win_5     (win[g][5]),
            .win_count (cnt)
        );
        assign wc[g] = 16'(cnt);
    end

    function automatic int s_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 2 : 6;
    endfunction

    function automatic int cw_of(int k);
        return (k < 2) ? 16 : 3;
    endfunction

    function automatic logic [191:0] w6(logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                        logic [31:0] d, logic [31:0] e, logic [31:0] f);
        return {a, b, c, d, e, f};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        p_name.push_back(name);
        p_act.push_back(act);
        p_exp.push_back(exp);
    endtask

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one sample and return just after the edge that accepted it; in_valid stays high
    task automatic send(int k, logic [31:0] d);
        bit got;
        got = 1'b0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = in_ready[k];
            @(posedge clk);
            #1;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_rst(int k);
        rst[k] = 1'b1;
        cycles(1);
        rst[k] = 1'b0;
    endtask

    task automatic pulse_clear(int k);
        clear[k] = 1'b1;
        cycles(1);
        clear[k] = 1'b0;
    endtask

    task automatic neg_chk(string name, logic [31:0] exp, int sel, int k);
        @(negedge clk);
        case (sel)
            0: chk(name, 32'(win_valid[k]), exp);
            1: chk(name, 32'(wc[k]), exp);
            2: chk(name, 32'(in_ready[k]), exp);
            default: chk(name, win[k][5], exp);
        endcase
        @(posedge clk);
        #1;
    endtask

    // Random traffic against a queue-based history of accepted samples
    task automatic rand_run(int k, int n);
        logic [31:0] hist [$];
        int fill;
        int scnt;
        int tot;
        fill = 0;
        scnt = 0;
        tot  = 0;
        pulse_rst(k);
        for (int i = 0; i < n; i++) begin
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            win_ready[k] = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: in_data[k] = 32'h0000_0000;
                1: in_data[k] = 32'hFFFF_FFFF;
                default: in_data[k] = $urandom;
            endcase
            @(negedge clk);
            if (in_valid[k] && in_ready[k]) begin
                hist.push_back(in_data[k]);
                if (hist.size() > 6) void'(hist.pop_front());
                if (fill < 6) begin
                    fill++;
                    if (fill == 6) begin
                        expq[k].push_back(w6(hist[0], hist[1], hist[2], hist[3], hist[4], hist[5]));
                        tot++;
                        scnt = 0;
                    end
                end else if (scnt == s_of(k) - 1) begin
                    expq[k].push_back(w6(hist[0], hist[1], hist[2], hist[3], hist[4], hist[5]));
                    tot++;
                    scnt = 0;
                end else begin
                    scnt++;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid[k]  = 1'b0;
        win_ready[k] = 1'b1;
        cycles(4);
        neg_chk("t6_count_wrap", 32'(tot % (1 << cw_of(k))), 1, k);
    endtask

    // Monitor: drains probes, pops the scoreboard on every hand-off, checks stall stability
    logic [191:0] hold [4];
    bit           stall_d [4] = '{default: 1'b0};
    always @(negedge clk) begin
        string        nm;
        logic [31:0]  a;
        logic [31:0]  e;
        logic [191:0] act;
        logic [191:0] ex;
        while (p_name.size() != 0) begin
            nm = p_name.pop_front();
            a  = p_act.pop_front();
            e  = p_exp.pop_front();
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", nm, a, e);
            end
        end
        for (int k = 0; k < 4; k++) begin
            act = {win[k][0], win[k][1], win[k][2], win[k][3], win[k][4], win[k][5]};
            if (stall_d[k] && win_valid[k]) begin
                n_vec++;
                if (act !== hold[k]) begin
                    n_bad++;
                    $display("FAIL hold_stable[%0d]: got %h expected %h", k, act, hold[k]);
                end
            end
            if (win_valid[k] && win_ready[k] && !rst[k] && !clear[k]) begin
                n_vec++;
                if (expq[k].size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_window[%0d]: got %h expected none", k, act);
                end else begin
                    ex = expq[k].pop_front();
                    if (act !== ex) begin
                        n_bad++;
                        $display("FAIL window[%0d]: got %h expected %h", k, act, ex);
                    end
                end
            end
            stall_d[k] = win_valid[k] && !win_ready[k] && !rst[k] && !clear[k];
            hold[k]    = act;
        end
        if (done && !final_done) begin
            final_done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (expq[k].size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_windows[%0d]: got %0d left expected 0", k, expq[k].size());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) in_data[k] = '0;
        in_valid = 4'hF;
        cycles(2);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst      = 4'h0;
        in_valid = 4'h0;
        @(negedge clk);
        chk("rst_win_valid", 32'(win_valid), 32'h0);
        chk("rst_count0", 32'(wc[0]), 0);
        chk("rst_count3", 32'(wc[3]), 0);
        chk("rst_win0", win[0][0], 0);
        chk("rst_win5", win[0][5], 0);
        @(posedge clk);
        #1;

        // 1: STRIDE 1 fill, latency, sliding
        win_ready[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) expq[0].push_back(w6(1, 2, 3, 4, 5, 6));
            send(0, 32'(i));
        end
        in_valid[0] = 1'b0;
        neg_chk("t1_latency", 1, 0, 0);
        expq[0].push_back(w6(2, 3, 4, 5, 6, 7));
        send(0, 32'd7);
        in_valid[0] = 1'b0;
        cycles(3);
        neg_chk("t1_count", 2, 1, 0);

        // 2: STRIDE 3 continuous stream
        win_ready[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 6)  expq[1].push_back(w6(1, 2, 3, 4, 5, 6));
            if (i == 9)  expq[1].push_back(w6(4, 5, 6, 7, 8, 9));
            if (i == 12) expq[1].push_back(w6(7, 8, 9, 10, 11, 12));
            send(1, 32'(i));
        end
        in_valid[1] = 1'b0;
        cycles(3);
        neg_chk("t2_count", 3, 1, 1);

        // 3: backpressure then back-to-back window
        pulse_rst(0);
        win_ready[0] = 1'b0;
        expq[0].push_back(w6(1, 2, 3, 4, 5, 6));
        expq[0].push_back(w6(2, 3, 4, 5, 6, 7));
        for (int i = 1; i <= 6; i++) send(0, 32'(i));
        in_data[0] = 32'd7;
        for (int i = 0; i < 5; i++) neg_chk("t3_stall_in_ready", 0, 2, 0);
        win_ready[0] = 1'b1;
        send(0, 32'd7);
        in_valid[0] = 1'b0;
        neg_chk("t3_b2b_valid", 1, 0, 0);
        cycles(2);
        neg_chk("t3_count", 2, 1, 0);

        // 4: clear mid-fill, then clear with a pending window
        pulse_clear(0);
        for (int i = 10; i <= 13; i++) send(0, 32'(i));
        clear[0]    = 1'b1;
        in_data[0]  = 32'd99;
        neg_chk("t4_clear_in_ready", 0, 2, 0);
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        expq[0].push_back(w6(20, 21, 22, 23, 24, 25));
        for (int i = 20; i <= 25; i++) send(0, 32'(i));
        in_valid[0] = 1'b0;
        cycles(3);
        neg_chk("t4_count", 3, 1, 0);
        pulse_clear(0);
        win_ready[0] = 1'b0;
        for (int i = 30; i <= 35; i++) send(0, 32'(i));
        in_valid[0] = 1'b0;
        neg_chk("t4_pending", 1, 0, 0);
        pulse_clear(0);
        neg_chk("t4_dropped_valid", 0, 0, 0);
        neg_chk("t4_dropped_count", 3, 1, 0);
        neg_chk("t4_win_held", 35, 3, 0);
        win_ready[0] = 1'b1;
        cycles(3);

        // 5: rst with pending window, together with clear and valid input
        pulse_clear(0);
        win_ready[0] = 1'b0;
        for (int i = 1; i <= 6; i++) send(0, 32'(i));
        rst[0]      = 1'b1;
        clear[0]    = 1'b1;
        in_data[0]  = 32'd99;
        neg_chk("t5_rst_in_ready", 0, 2, 0);
        rst[0]      = 1'b0;
        clear[0]    = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(win_valid[0]), 0);
        chk("t5_count", 32'(wc[0]), 0);
        chk("t5_win0", win[0][0], 0);
        chk("t5_win5", win[0][5], 0);
        @(posedge clk);
        #1;
        win_ready[0] = 1'b1;
        expq[0].push_back(w6(40, 41, 42, 43, 44, 45));
        for (int i = 40; i <= 45; i++) send(0, 32'(i));
        in_valid[0] = 1'b0;
        cycles(3);
        neg_chk("t5_refill_count", 1, 1, 0);

        // 6: random traffic with extreme values, STRIDE 1/2/6, count wrap on 3-bit instances
        rand_run(0, 150);
        rand_run(2, 200);
        rand_run(3, 300);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
